// File: rtl/coax_rx_clock_recovery.sv
// Receive-side bit clock recovery for the bi-phase coax line: synchronise and deglitch rx,
// lock a phase counter to mid-bit transitions and strobe once per bit at the sample point.
module coax_rx_clock_recovery #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CLOCKS  = 1,
  parameter int EDGE_WINDOW    = 2,
  parameter int SAMPLE_OFFSET  = 6,
  parameter int LOSS_BITS      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_filtered,
  output logic sample,
  output logic sample_value,
  output logic synchronized,
  output logic sync_lost
);

  localparam int PW = $clog2(CLOCKS_PER_BIT);
  localparam int FW = $clog2(FILTER_CLOCKS + 1);
  localparam int MW = $clog2(LOSS_BITS + 1);

  localparam logic [PW-1:0] P_LAST   = PW'(CLOCKS_PER_BIT - 1);
  localparam logic [PW-1:0] P_LATE   = PW'(CLOCKS_PER_BIT - EDGE_WINDOW);
  localparam logic [PW-1:0] P_EARLY  = PW'(EDGE_WINDOW);
  localparam logic [PW-1:0] P_SAMPLE = PW'(SAMPLE_OFFSET);
  localparam logic [FW-1:0] F_LIMIT  = FW'(FILTER_CLOCKS);
  localparam logic [MW-1:0] M_LAST   = MW'(LOSS_BITS - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FW-1:0]          f;
  logic                   rx_filtered_d;
  logic                   rx_edge;

  state_t        state;
  logic [PW-1:0] p;
  logic [MW-1:0] m;
  logic          wrap;
  logic          accept;

  // NOTE: every flop here is state, so all sequential blocks use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // rx_filtered only follows s after a run of disagreement; a shorter pulse just clears f.
  always_ff @(posedge clk) begin
    if (reset) begin
      f             <= '0;
      rx_filtered   <= 1'b0;
      rx_filtered_d <= 1'b0;
    end else begin
      rx_filtered_d <= rx_filtered;
      if (s == rx_filtered) begin
        f <= '0;
      end else if (f == F_LIMIT) begin
        rx_filtered <= s;
        f           <= '0;
      end else begin
        f <= f + 1'b1;
      end
    end
  end

  assign rx_edge = rx_filtered != rx_filtered_d;
  assign wrap    = p == P_LAST;
  // Transitions near p==0 are mid-bit and re-zero the phase; the rest are bit boundaries.
  assign accept  = rx_edge && ((p >= P_LATE) || (p <= P_EARLY));
  assign sample  = (state == LOCKED) && (p == P_SAMPLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HUNT;
      p            <= '0;
      m            <= '0;
      synchronized <= 1'b0;
      sync_lost    <= 1'b0;
      sample_value <= 1'b0;
    end else begin
      sync_lost <= 1'b0;
      if (sample) sample_value <= rx_filtered;
      unique case (state)
        HUNT: begin
          p <= '0;
          m <= '0;
          if (rx_edge) begin
            state        <= LOCKED;
            synchronized <= 1'b1;
          end
        end
        LOCKED: begin
          if (accept) begin
            p <= '0;
            m <= '0;
          end else if (wrap) begin
            p <= '0;
            // Flywheel: count silent bit periods and give up after LOSS_BITS of them.
            if (m == M_LAST) begin
              state        <= HUNT;
              synchronized <= 1'b0;
              sync_lost    <= 1'b1;
              m            <= '0;
            end else begin
              m <= m + 1'b1;
            end
          end else begin
            p <= p + 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_coax_rx_clock_recovery.sv
// Directed bench for coax_rx_clock_recovery: bi-phase streams (first half = bit value),
// drift, glitch, flywheel loss and reset while locked, with hand-derived timing.
module tb_coax_rx_clock_recovery;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b0;
  logic rx_filtered, sample, sample_value, synchronized, sync_lost;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Event logs written only by the monitor.
  int   samp_q[$];
  logic val_q[$];
  int   rise_q[$];
  int   lost_q[$];
  int   drop_q[$];
  int   rf_toggles  = 0;
  logic val_pending = 1'b0;
  logic prev_sync   = 1'b0;
  logic prev_rf     = 1'b0;

  // Stimulus bookkeeping written only by the initial block.
  int mid_q[$];
  int exp_toggles;
  int base_samp, base_val, base_rise, base_lost, base_drop, base_tog;

  coax_rx_clock_recovery #(
    .CLOCKS_PER_BIT(8),
    .SYNC_STAGES   (2),
    .FILTER_CLOCKS (1),
    .EDGE_WINDOW   (2),
    .SAMPLE_OFFSET (6),
    .LOSS_BITS     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_filtered (rx_filtered),
    .sample      (sample),
    .sample_value(sample_value),
    .synchronized(synchronized),
    .sync_lost   (sync_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (val_pending) val_q.push_back(sample_value);
    val_pending = sample;
    if (sample) samp_q.push_back(cyc);
    if (sync_lost) lost_q.push_back(cyc);
    if (synchronized && !prev_sync) rise_q.push_back(cyc);
    if (!synchronized && prev_sync) drop_q.push_back(cyc);
    if (rx_filtered !== prev_rf) rf_toggles++;
    prev_sync = synchronized;
    prev_rf   = rx_filtered;
  end

  task automatic mark_bases();
    base_samp = samp_q.size();
    base_val  = val_q.size();
    base_rise = rise_q.size();
    base_lost = lost_q.size();
    base_drop = drop_q.size();
    base_tog  = rf_toggles;
  endtask

  // Drive v for n cycles; entered and left just after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Cell 0 is a sync bit equal to the idle level so the first transition is mid-bit.
  task automatic send_stream(input logic [15:0] data, input int n, input int drift_every,
                             input int glitch_cell);
    logic b;
    @(posedge clk);
    #1;
    mid_q.delete();
    exp_toggles = 0;
    mark_bases();
    hold(rx, 12);
    for (int k = 0; k <= n; k++) begin
      b = (k == 0) ? rx : data[k-1];
      if (b !== rx) exp_toggles++;
      if (k == glitch_cell) begin
        hold(b, 2);
        hold(~b, 1);
        hold(b, 1);
      end else begin
        hold(b, 4);
      end
      mid_q.push_back(cyc);
      exp_toggles++;
      hold(~b, (drift_every > 0 && (k % drift_every) == drift_every - 1) ? 5 : 4);
    end
    hold(rx, 30);
  endtask

  task automatic check_stream(input string name, input logic [15:0] data, input int n);
    int   last_mid, exp_c, act_c, act_i, min_gap;
    logic exp_v, act_v;
    last_mid = mid_q[n];

    act_i = (rise_q.size() > base_rise) ? rise_q[base_rise] : -1;
    checks++;
    if (rise_q.size() - base_rise != 1 || act_i !== mid_q[0] + 5) begin
      errors++;
      $display("FAIL %s lock_time: got %0d rises, first at %0d, expected 1 at %0d",
               name, rise_q.size() - base_rise, act_i, mid_q[0] + 5);
    end

    checks++;
    if (samp_q.size() - base_samp != n + 2) begin
      errors++;
      $display("FAIL %s sample_count: got %0d, expected %0d", name,
               samp_q.size() - base_samp, n + 2);
    end

    for (int k = 0; k <= n + 1; k++) begin
      exp_c = (k <= n) ? mid_q[k] + 11 : last_mid + 19;
      exp_v = (k < n) ? data[k] : ~data[n-1];
      act_c = (base_samp + k < samp_q.size()) ? samp_q[base_samp + k] : -1;
      act_v = (base_val + k < val_q.size()) ? val_q[base_val + k] : 1'bx;
      checks++;
      if (act_c !== exp_c) begin
        errors++;
        $display("FAIL %s sample_time[%0d]: got cycle %0d, expected %0d", name, k, act_c, exp_c);
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s sample_value[%0d]: got %b, expected %b", name, k, act_v, exp_v);
      end
    end

    min_gap = 1000;
    for (int k = base_samp + 1; k < samp_q.size(); k++)
      if (samp_q[k] - samp_q[k-1] < min_gap) min_gap = samp_q[k] - samp_q[k-1];
    checks++;
    if (min_gap < 4) begin
      errors++;
      $display("FAIL %s strobe_spacing: got min gap %0d, expected >= 4", name, min_gap);
    end

    act_i = (lost_q.size() > base_lost) ? lost_q[base_lost] : -1;
    checks++;
    if (lost_q.size() - base_lost != 1 || act_i !== last_mid + 21) begin
      errors++;
      $display("FAIL %s sync_lost: got %0d pulses, first at %0d, expected 1 at %0d",
               name, lost_q.size() - base_lost, act_i, last_mid + 21);
    end

    act_i = (drop_q.size() > base_drop) ? drop_q[base_drop] : -1;
    checks++;
    if (drop_q.size() - base_drop != 1 || act_i !== last_mid + 21) begin
      errors++;
      $display("FAIL %s sync_drop: got %0d drops, first at %0d, expected 1 at %0d",
               name, drop_q.size() - base_drop, act_i, last_mid + 21);
    end

    checks++;
    if (rf_toggles - base_tog != exp_toggles) begin
      errors++;
      $display("FAIL %s rx_filtered_toggles: got %0d, expected %0d", name,
               rf_toggles - base_tog, exp_toggles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx_filtered, sample, sample_value, synchronized, sync_lost} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000",
               {rx_filtered, sample, sample_value, synchronized, sync_lost});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    mark_bases();
    @(negedge clk);
    checks++;
    if ({rx_filtered, sample, sample_value, synchronized, sync_lost} !== 5'b0) begin
      errors++;
      $display("FAIL first_cycle_outputs: got %b, expected 00000",
               {rx_filtered, sample, sample_value, synchronized, sync_lost});
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (samp_q.size() != base_samp || rise_q.size() != base_rise || synchronized !== 1'b0) begin
      errors++;
      $display("FAIL idle_hunt: got %0d samples, %0d locks, synchronized=%b, expected 0 0 0",
               samp_q.size() - base_samp, rise_q.size() - base_rise, synchronized);
    end
  endtask

  task automatic test_ideal_stream();
    send_stream(16'h00B2, 8, 0, -1);
    check_stream("ideal", 16'h00B2, 8);
  endtask

  task automatic test_drift();
    send_stream(16'hC5A3, 12, 4, -1);
    check_stream("drift", 16'hC5A3, 12);
  endtask

  task automatic test_glitch();
    send_stream(16'h0029, 6, 0, 3);
    check_stream("glitch", 16'h0029, 6);
  endtask

  task automatic test_flywheel();
    send_stream(16'h0006, 3, 0, -1);
    check_stream("flywheel", 16'h0006, 3);
  endtask

  task automatic test_reset_locked();
    int t, t2;
    @(posedge clk);
    #1;
    hold(1'b0, 12);
    t = cyc;
    hold(1'b1, 10);
    reset = 1'b1;
    rx    = 1'b0;
    @(negedge clk);
    checks++;
    if (synchronized !== 1'b1) begin
      errors++;
      $display("FAIL locked_before_reset: got synchronized=%b at cycle %0d (lock at %0d), expected 1",
               synchronized, cyc, t + 5);
    end
    @(negedge clk);
    checks++;
    if ({synchronized, sample, sync_lost} !== 3'b000) begin
      errors++;
      $display("FAIL reset_while_locked: got sync/sample/lost=%b, expected 000",
               {synchronized, sample, sync_lost});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    mark_bases();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (synchronized !== 1'b0 || lost_q.size() != base_lost) begin
      errors++;
      $display("FAIL after_reset_quiet: got synchronized=%b, %0d sync_lost pulses, expected 0 0",
               synchronized, lost_q.size() - base_lost);
    end
    t2 = cyc;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (synchronized !== 1'b0) begin
      errors++;
      $display("FAIL relock_early: got synchronized=%b at t+4, expected 0", synchronized);
    end
    @(negedge clk);
    checks++;
    if (synchronized !== 1'b1 || cyc != t2 + 5) begin
      errors++;
      $display("FAIL relock: got synchronized=%b at cycle %0d, expected 1 at %0d",
               synchronized, cyc, t2 + 5);
    end
  endtask

  initial begin
    test_reset();
    test_ideal_stream();
    test_drift();
    test_glitch();
    test_flywheel();
    test_reset_locked();
    repeat (30) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
